// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding and
// the number of FIFO frames one ALU result is split into.
package alu_result_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    SEND_FIRST  = 2'b01,
    SEND_SECOND = 2'b10
  } state_t;

  localparam int FRAME_COUNT = 2;

endpackage

// File: rtl/alu_result_serializer.sv
// Captures a 2*Data_width ALU result and writes it to the TX FIFO as two
// Data_width frames, one per cycle, honouring FIFO_Full backpressure.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int Data_width = 8,
  parameter bit MSB_first  = 1'b0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [FRAME_COUNT*Data_width-1:0] ALU_Out,
  input  logic                              ALU_Out_Valid,
  input  logic                              FIFO_Full,
  output logic [Data_width-1:0]             Wr_Data,
  output logic                              Wr_Inc,
  output logic                              Ready,
  output logic                              Busy,
  output logic                              Overrun
);

  state_t                            state;
  state_t                            state_next;
  logic [FRAME_COUNT*Data_width-1:0] capture;
  logic [Data_width-1:0]             frame_lo;
  logic [Data_width-1:0]             frame_hi;
  logic [Data_width-1:0]             first_frame;
  logic [Data_width-1:0]             second_frame;
  logic                              accept;

  assign frame_lo     = capture[Data_width-1:0];
  assign frame_hi     = capture[FRAME_COUNT*Data_width-1:Data_width];
  assign first_frame  = MSB_first ? frame_hi : frame_lo;
  assign second_frame = MSB_first ? frame_lo : frame_hi;

  // Frame select follows the registered state only, so a stall keeps it stable.
  assign Wr_Data = (state == SEND_SECOND) ? second_frame : first_frame;
  assign accept  = ALU_Out_Valid & Ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    Wr_Inc     = 1'b0;
    Ready      = 1'b0;
    Busy       = 1'b1;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        Busy  = 1'b0;
        if (ALU_Out_Valid) state_next = SEND_FIRST;
      end
      SEND_FIRST: begin
        if (!FIFO_Full) begin
          Wr_Inc     = 1'b1;
          state_next = SEND_SECOND;
        end
      end
      SEND_SECOND: begin
        if (!FIFO_Full) begin
          Wr_Inc     = 1'b1;
          Ready      = 1'b1;
          state_next = ALU_Out_Valid ? SEND_FIRST : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      // NOTE: the capture register is reset too, so Wr_Data reads 0 out of reset.
      capture <= '0;
      Overrun <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state   <= state_next;
      Overrun <= ALU_Out_Valid & ~Ready;
      // Only an accepted result may touch the capture register.
      if (accept) capture <= ALU_Out;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a frame-queue model of the serializer for both frame orders.
module tb_alu_result_serializer;

  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [2*DW-1:0] alu_out;
  logic            alu_valid;
  logic            fifo_full;

  logic [DW-1:0] wr_data_l, wr_data_m;
  logic          wr_inc_l, wr_inc_m;
  logic          ready_l, ready_m;
  logic          busy_l, busy_m;
  logic          overrun_l, overrun_m;

  int checks = 0;
  int errors = 0;

  // Model: frames still owed to the FIFO, in write order, per frame order.
  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_m[$];
  bit            ovr_model;

  always #5 CLK = ~CLK;

  alu_result_serializer #(.Data_width(DW), .MSB_first(1'b0)) u_lsb (
    .CLK(CLK), .RST(RST), .ALU_Out(alu_out), .ALU_Out_Valid(alu_valid),
    .FIFO_Full(fifo_full), .Wr_Data(wr_data_l), .Wr_Inc(wr_inc_l),
    .Ready(ready_l), .Busy(busy_l), .Overrun(overrun_l)
  );

  alu_result_serializer #(.Data_width(DW), .MSB_first(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .ALU_Out(alu_out), .ALU_Out_Valid(alu_valid),
    .FIFO_Full(fifo_full), .Wr_Data(wr_data_m), .Wr_Inc(wr_inc_m),
    .Ready(ready_m), .Busy(busy_m), .Overrun(overrun_m)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs at the falling edge,
  // then advance the model across the rising edge.
  task automatic cycle(input bit v, input logic [2*DW-1:0] d, input bit f);
    bit m_ready;
    bit m_inc;
    alu_valid = v;
    alu_out   = d;
    fifo_full = f;
    @(negedge CLK);
    m_ready = (q_l.size() == 0) || (q_l.size() == 1 && !f);
    m_inc   = (q_l.size() > 0) && !f;
    check("ready_lsb",   ready_l,   m_ready);
    check("ready_msb",   ready_m,   m_ready);
    check("busy_lsb",    busy_l,    q_l.size() > 0);
    check("busy_msb",    busy_m,    q_m.size() > 0);
    check("wr_inc_lsb",  wr_inc_l,  m_inc);
    check("wr_inc_msb",  wr_inc_m,  m_inc);
    check("overrun_lsb", overrun_l, ovr_model);
    check("overrun_msb", overrun_m, ovr_model);
    if (q_l.size() > 0) check("wr_data_lsb", wr_data_l, q_l[0]);
    if (q_m.size() > 0) check("wr_data_msb", wr_data_m, q_m[0]);
    @(posedge CLK);
    #1;
    if (m_inc) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    if (v && m_ready) begin
      q_l.push_back(d[DW-1:0]);
      q_l.push_back(d[2*DW-1:DW]);
      q_m.push_back(d[2*DW-1:DW]);
      q_m.push_back(d[DW-1:0]);
    end
    ovr_model = v && !m_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_inc"},  {wr_inc_m, wr_inc_l},       2'b00);
    check({tag, "_wr_data"}, {wr_data_m, wr_data_l},     16'h0000);
    check({tag, "_busy"},    {busy_m, busy_l},           2'b00);
    check({tag, "_overrun"}, {overrun_m, overrun_l},     2'b00);
    check({tag, "_ready"},   {ready_m, ready_l},         2'b11);
  endtask

  initial begin
    RST       = 1'b1;
    alu_out   = '0;
    alu_valid = 1'b0;
    fifo_full = 1'b0;
    ovr_model = 1'b0;
    #13;
    check_reset_values("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    // Single result, no backpressure; then high-first instance order.
    cycle(1'b1, 16'hA55A, 1'b0);
    idle(3);
    cycle(1'b1, 16'h1234, 1'b0);
    idle(3);

    // Three-cycle stall on the first frame.
    cycle(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'hFFFF, 1'b1);
    idle(3);

    // Back-to-back results with no bubble.
    cycle(1'b1, 16'h0102, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 16'h0304, 1'b0);
    idle(4);

    // Second valid while sending the first frame is dropped.
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    idle(4);

    // Valid in SEND_SECOND while the FIFO is full is also dropped.
    cycle(1'b1, 16'h3344, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 16'h5566, 1'b1);
    idle(4);

    // Asynchronous reset while the second frame is pending.
    cycle(1'b1, 16'h7788, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    alu_valid = 1'b0;
    fifo_full = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_reset_values("midreset");
    q_l.delete();
    q_m.delete();
    ovr_model = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(4);

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) == 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
